// File: rtl/io_uart_tx.sv
// io_uart_tx: buffers 32-bit core IO writes in a FIFO and sends each word as 4 UART frames, LSB byte first.
// Define IO_UART_TX_PARITY_EN for 8E1 frames; default build is 8N1.
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic             tx,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef IO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [1:0]          byte_q, byte_d;
  logic [31:0]         shreg_q, shreg_d;
  logic                tx_q, tx_d;
  logic [31:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                overflow_q;
  logic                pop, push, baud_end;

  always_comb begin
    pop      = (state_q == S_IDLE) && (count_q != '0);
    push     = din_valid && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
    baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (pop) begin
          state_d = S_START;
          shreg_d = mem[rptr_q];
          byte_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef IO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shreg_d = {8'h00, shreg_q[31:8]};
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so tx is a clean flop aligned with state entry.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[bit_d];
`ifdef IO_UART_TX_PARITY_EN
      S_PARITY: tx_d = ^shreg_d[7:0];
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (din_valid && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wptr_q] <= din;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: queue/waveform reference model plus directed literal checks.
module tb_io_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
`ifdef IO_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WL = 4 * FB * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   din = '0;
  logic          din_valid = 1'b0;
  logic          tx, busy, overflow;
  logic [CW-1:0] fifo_count;

  io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word queue plus the full line waveform of the word on the wire.
  logic [31:0] mq[$];
  logic        m_wave [WL];
  int          m_pos = 0;
  bit          m_active = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_pop, m_push;

  function automatic void build(input logic [31:0] w);
    int p = 0;
    for (int b = 0; b < 4; b++) begin
      logic [7:0] by = w[8*b +: 8];
      for (int j = 0; j < CPB; j++) m_wave[p++] = 1'b0;
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < CPB; j++) m_wave[p++] = by[k];
      if (FB == 11)
        for (int j = 0; j < CPB; j++) m_wave[p++] = ^by;
      for (int j = 0; j < CPB; j++) m_wave[p++] = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      m_pop  = !m_active && (mq.size() > 0);
      m_push = din_valid && ((mq.size() < DEPTH) || m_pop);
      if (m_active) begin
        m_pos++;
        if (m_pos == WL) m_active = 1'b0;
      end
      if (m_pop) begin
        build(mq.pop_front());
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (m_push) mq.push_back(din);
      if (din_valid && !m_push) m_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_tx", {31'b0, tx}, m_active ? {31'b0, m_wave[m_pos]} : 32'd1);
      chk("model_busy", {31'b0, busy}, {31'b0, (m_active || mq.size() != 0)});
      chk("model_overflow", {31'b0, overflow}, {31'b0, m_ovf});
      chk("model_count", {27'b0, fifo_count}, mq.size());
    end
  end

  logic          rec_tx   [WL+4];
  logic          rec_busy [WL+4];
  logic [CW-1:0] rec_cnt  [WL+4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    din       = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Waits (bounded) for the start bit, then records WL+4 clocks of line activity; rec index 0 = first low clock.
  task automatic capture(output int lat);
    int k = 0;
    @(negedge clk);
    while (tx !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    lat = k;
    if (k >= 20) chk("start_timeout", {31'b0, tx}, 32'd0);
    for (int t = 0; t < WL + 4; t++) begin
      if (t > 0) @(negedge clk);
      rec_tx[t]   = tx;
      rec_busy[t] = busy;
      rec_cnt[t]  = fifo_count;
    end
  endtask

  function automatic logic [7:0] dec(input int f);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = rec_tx[f*FB*CPB + (1+b)*CPB + CPB/2];
    return v;
  endfunction

  task automatic wait_idle(input int limit);
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int            lat;
    logic [10:0]   a5_bits;
    logic [7:0]    exp_bytes [4];
    int            lows;

    do_reset(3);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_tx", {31'b0, tx}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_overflow", {31'b0, overflow}, 32'd0);
    chk("reset_count", {27'b0, fifo_count}, 32'd0);

    // Single word 0x000000A5
`ifdef IO_UART_TX_PARITY_EN
    a5_bits = 11'b10101001010;
`else
    a5_bits = 11'b01101001010;
`endif
    tick();
    push(32'h0000_00A5);
    capture(lat);
    chk("start_latency", lat, 32'd1);
    for (int k = 0; k < FB; k++)
      for (int j = 0; j < CPB; j++)
        chk("a5_bit", {31'b0, rec_tx[k*CPB + j]}, {31'b0, a5_bits[k]});
    for (int f = 1; f < 4; f++) chk("a5_zero_byte", {24'b0, dec(f)}, 32'h0);
    chk("a5_busy_last", {31'b0, rec_busy[WL-1]}, 32'd1);
    chk("a5_busy_drop", {31'b0, rec_busy[WL]}, 32'd0);
    chk("a5_count_end", {27'b0, rec_cnt[WL]}, 32'd0);

    // Byte order and gapless frames
    push(32'h1234_5678);
    capture(lat);
    exp_bytes[0] = 8'h78; exp_bytes[1] = 8'h56; exp_bytes[2] = 8'h34; exp_bytes[3] = 8'h12;
    for (int f = 0; f < 4; f++) begin
      chk("le_byte", {24'b0, dec(f)}, {24'b0, exp_bytes[f]});
      chk("frame_start", {31'b0, rec_tx[f*FB*CPB + CPB/2]}, 32'd0);
      chk("frame_stop", {31'b0, rec_tx[f*FB*CPB + (FB-1)*CPB + CPB/2]}, 32'd1);
      if (f > 0) chk("no_gap", {31'b0, rec_tx[f*FB*CPB]}, 32'd0);
    end

`ifdef IO_UART_TX_PARITY_EN
    push(32'h0000_0007);
    capture(lat);
    chk("parity_b0", {31'b0, rec_tx[9*CPB + 2]}, 32'd1);
    for (int f = 1; f < 4; f++) chk("parity_bn", {31'b0, rec_tx[f*FB*CPB + 9*CPB + 2]}, 32'd0);
    chk("parity_busy_last", {31'b0, rec_busy[175]}, 32'd1);
    chk("parity_busy_drop", {31'b0, rec_busy[176]}, 32'd0);
`endif

    // Overflow: 18 back-to-back writes into a 16-deep FIFO
    for (int i = 1; i <= 18; i++) begin
      din       = i;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    @(negedge clk);
    chk("ovf_count_full", {27'b0, fifo_count}, 32'd16);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    wait_idle(4000);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);
    chk("ovf_count_drained", {27'b0, fifo_count}, 32'd0);

    // Push coinciding with pop while full
    do_reset(1);
    for (int i = 0; i < 17; i++) begin
      din       = 32'h100 + i;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!m_active && mq.size() > 0) break;
    end
    chk("full_before_pp", {27'b0, fifo_count}, 32'd16);
    din       = 32'h0000_BEEF;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    chk("pp_count", {27'b0, fifo_count}, 32'd16);
    chk("pp_overflow", {31'b0, overflow}, 32'd0);

    // Reset in the middle of byte 1's data bits
    do_reset(1);
    push(32'hAAAA_5555);
    push(32'h0F0F_0F0F);
    lows = 0;
    @(negedge clk);
    while (tx !== 1'b0 && lows < 20) begin
      @(negedge clk);
      lows++;
    end
    if (lows >= 20) chk("rst_start_timeout", {31'b0, tx}, 32'd0);
    repeat (FB*CPB + 4*CPB) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_tx", {31'b0, tx}, 32'd1);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_count", {27'b0, fifo_count}, 32'd0);
    chk("midrst_overflow", {31'b0, overflow}, 32'd0);
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("midrst_quiet", lows, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
